spi_bitrev_slave: RTL and testbench

SPI_BITREV_SLAVE -- requirements
Module: spi_bitrev_slave

---
 rtl/spi_bitrev_slave.sv | 175 +++++++++++++++++
 tb/tb_spi_bitrev_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bitrev_slave.sv
// SPI slave that captures a WIDTH-bit word MSB-first, then echoes it back LSB-first on miso.
// Optional frame_err output is compiled in with `define SPI_BITREV_FRAME_ERR_EN.
//
// state | meaning
// IDLE  | waiting for ss low; miso held at 1
// RX    | shifting mosi in on each sample edge
// TX    | driving received bits LSB-first on each shift edge
// DONE  | frame complete; miso 1, mosi ignored until ss rises
module spi_bitrev_slave #(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
`ifdef SPI_BITREV_FRAME_ERR_EN
    output logic             frame_err,
`endif
    output logic             rx_valid
);

    localparam int CW = $clog2(2 * WIDTH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] C_W  = CW'(WIDTH);
    localparam logic [CW-1:0] C_2W = CW'(2 * WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_TX, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_sample_stb;
    logic                   r_shift_stb;
    logic [SW-1:0]          r_settle;
    logic                   r_armed;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_shreg;
    logic                   r_miso;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
`ifdef SPI_BITREV_FRAME_ERR_EN
    logic                   r_frame_err;
`endif

    logic          w_sck;
    logic          w_ss;
    logic          w_mosi;
    logic [CW-1:0] w_tx_idx;
    logic          w_tx_bit;

    assign w_sck    = r_sck_sync[SYNC_STAGES-1] ^ CPOL;
    assign w_ss     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_tx_idx = r_cnt - C_W;
    assign w_tx_bit = |(r_shreg & (WIDTH'(1) << w_tx_idx));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sck_sync  <= {SYNC_STAGES{CPOL}};
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    // Strobes are registered so the FSM reacts SYNC_STAGES+2 clocks after the pin edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sck_d      <= 1'b0;
            r_sample_stb <= 1'b0;
            r_shift_stb  <= 1'b0;
        end else begin
            r_sck_d      <= w_sck;
            r_sample_stb <= w_sck & ~r_sck_d;
            r_shift_stb  <= ~w_sck & r_sck_d;
        end
    end

    // Arming waits until the synchronizer has flushed its reset value, so only a real
    // ss high level seen after reset allows the next frame to begin.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != SW'(SYNC_STAGES))
                r_settle <= r_settle + 1'b1;
            else if (w_ss)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_miso      <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
`ifdef SPI_BITREV_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_rx_valid  <= 1'b0;
`ifdef SPI_BITREV_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            if (w_ss) begin
`ifdef SPI_BITREV_FRAME_ERR_EN
                if (r_state == ST_RX || r_state == ST_TX)
                    r_frame_err <= 1'b1;
`endif
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_shreg <= '0;
                r_miso  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso  <= 1'b1;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                        if (r_armed)
                            r_state <= ST_RX;
                    end
                    ST_RX: begin
                        r_miso <= 1'b1;
                        if (r_cnt == C_W) begin
                            r_state    <= ST_TX;
                            r_rx_data  <= r_shreg;
                            r_rx_valid <= 1'b1;
                        end else if (r_sample_stb) begin
                            r_shreg <= {r_shreg[WIDTH-2:0], w_mosi};
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (r_cnt == C_2W) begin
                            r_state <= ST_DONE;
                        end else begin
                            if (r_shift_stb)
                                r_miso <= w_tx_bit;
                            if (r_sample_stb)
                                r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (r_shift_stb)
                            r_miso <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`ifdef SPI_BITREV_FRAME_ERR_EN
    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave: three instances (8-bit CPOL0, 16-bit CPOL0 3-stage sync, 8-bit CPOL1)
// driven by an SPI master model; echoes are checked against a word-level reference.
module tb_spi_bitrev_slave;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] sck_p  = 3'b100;
    logic [2:0] ss_p   = 3'b111;
    logic [2:0] mosi_p = 3'b000;
    logic       miso_a, miso_b, miso_c;
    logic [7:0]  rx_a;
    logic [15:0] rx_b;
    logic [7:0]  rx_c;
    logic       rxv_a, rxv_b, rxv_c;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
`ifdef SPI_BITREV_FRAME_ERR_EN
    logic ferr_a, ferr_b, ferr_c;
    int   fcnt_a = 0;
`endif

    localparam bit [2:0] CPOLS = 3'b100;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] last_a = '0;

    always #5 clock = ~clock;

    spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b0), .SYNC_STAGES(2)) u_a (
        .clock(clock), .resetn(resetn), .sck(sck_p[0]), .ss(ss_p[0]), .mosi(mosi_p[0]),
        .miso(miso_a), .rx_data(rx_a),
`ifdef SPI_BITREV_FRAME_ERR_EN
        .frame_err(ferr_a),
`endif
        .rx_valid(rxv_a));

    spi_bitrev_slave #(.WIDTH(16), .CPOL(1'b0), .SYNC_STAGES(3)) u_b (
        .clock(clock), .resetn(resetn), .sck(sck_p[1]), .ss(ss_p[1]), .mosi(mosi_p[1]),
        .miso(miso_b), .rx_data(rx_b),
`ifdef SPI_BITREV_FRAME_ERR_EN
        .frame_err(ferr_b),
`endif
        .rx_valid(rxv_b));

    spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b1), .SYNC_STAGES(2)) u_c (
        .clock(clock), .resetn(resetn), .sck(sck_p[2]), .ss(ss_p[2]), .mosi(mosi_p[2]),
        .miso(miso_c), .rx_data(rx_c),
`ifdef SPI_BITREV_FRAME_ERR_EN
        .frame_err(ferr_c),
`endif
        .rx_valid(rxv_c));

    always @(posedge clock) if (rxv_a) vcnt_a <= vcnt_a + 1;
    always @(posedge clock) if (rxv_b) vcnt_b <= vcnt_b + 1;
    always @(posedge clock) if (rxv_c) vcnt_c <= vcnt_c + 1;
`ifdef SPI_BITREV_FRAME_ERR_EN
    always @(posedge clock) if (ferr_a) fcnt_a <= fcnt_a + 1;
`endif

    function automatic logic get_miso(int i);
        case (i)
            0:       return miso_a;
            1:       return miso_b;
            default: return miso_c;
        endcase
    endfunction

    function automatic logic [31:0] get_rx(int i);
        case (i)
            0:       return {24'd0, rx_a};
            1:       return {16'd0, rx_b};
            default: return {24'd0, rx_c};
        endcase
    endfunction

    function automatic logic get_rxv(int i);
        case (i)
            0:       return rxv_a;
            1:       return rxv_b;
            default: return rxv_c;
        endcase
    endfunction

    function automatic int get_vcnt(int i);
        case (i)
            0:       return vcnt_a;
            1:       return vcnt_b;
            default: return vcnt_c;
        endcase
    endfunction

    function automatic int width_of(int i);
        return (i == 1) ? 16 : 8;
    endfunction

    // Reference: miso seen by the master at the leading edge of SCK clock j.
    // Clocks 0..w-1 receive (miso idle 1), clocks w..2w-1 return bit (j-w), later clocks read 1.
    function automatic logic [63:0] exp_echo(int w, logic [31:0] word, int nclk);
        logic [63:0] e;
        e = '1;
        for (int j = 0; j < nclk; j++)
            if (j >= w && j < 2 * w) e[j] = word[j - w];
        return e;
    endfunction

    task automatic wait_clk(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ss_set(int i, logic v);
        ss_p[i] = v;
        wait_clk(8);
    endtask

    task automatic sck_cycle(int i, logic m, output logic s);
        mosi_p[i] = m;
        wait_clk(8);
        s = get_miso(i);
        sck_p[i] = ~CPOLS[i];
        wait_clk(8);
        sck_p[i] = CPOLS[i];
    endtask

    task automatic run_frame(int i, int w, logic [31:0] word, int nclk, output logic [63:0] got);
        logic s;
        logic m;
        got = '1;
        ss_set(i, 1'b0);
        for (int j = 0; j < nclk; j++) begin
            m = (j < w) ? word[w - 1 - j] : 1'($urandom);
            sck_cycle(i, m, s);
            got[j] = s;
        end
        ss_set(i, 1'b1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wait_clk(3);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (get_miso(i) !== 1'b1 || get_rx(i) !== 32'd0 || get_rxv(i) !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state inst%0d: miso=%b rx=%h rxv=%b, need miso=1 rx=0 rxv=0",
                         i, get_miso(i), get_rx(i), get_rxv(i));
            end
        end
        resetn = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (get_miso(i) !== 1'b1 || get_vcnt(i) != 0) begin
                nerr++;
                $display("FAIL post_reset_idle inst%0d: miso=%b valids=%0d, need miso=1 valids=0",
                         i, get_miso(i), get_vcnt(i));
            end
        end
    endtask

    task automatic test_basic_b4();
        logic [63:0] got, exp;
        logic [7:0]  echo;
        int v0;
        v0 = vcnt_a;
        run_frame(0, 8, 32'hB4, 16, got);
        exp = exp_echo(8, 32'hB4, 16);
        last_a = 32'hB4;
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL b4_miso_stream: got=%h need=%h", got[15:0], exp[15:0]);
        end
        for (int k = 0; k < 8; k++) echo[7 - k] = got[8 + k];
        nvec++;
        if (echo !== 8'h2D) begin
            nerr++;
            $display("FAIL b4_echo_byte: got=%h need=2d", echo);
        end
        nvec++;
        if (rx_a !== 8'hB4) begin
            nerr++;
            $display("FAIL b4_rx_data: got=%h need=b4", rx_a);
        end
        nvec++;
        if (vcnt_a - v0 != 1) begin
            nerr++;
            $display("FAIL b4_rx_valid_count: got=%0d need=1", vcnt_a - v0);
        end
    endtask

    task automatic test_wide_8001();
        logic [63:0] got, exp;
        int v0;
        v0 = vcnt_b;
        run_frame(1, 16, 32'h8001, 36, got);
        exp = exp_echo(16, 32'h8001, 36);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL w16_miso_stream: got=%h need=%h", got[35:0], exp[35:0]);
        end
        nvec++;
        if (got[35:32] !== 4'hF) begin
            nerr++;
            $display("FAIL w16_extra_clocks: got=%b need=1111", got[35:32]);
        end
        nvec++;
        if (rx_b !== 16'h8001 || vcnt_b - v0 != 1) begin
            nerr++;
            $display("FAIL w16_rx: rx=%h valids=%0d, need rx=8001 valids=1", rx_b, vcnt_b - v0);
        end
    endtask

    task automatic test_cpol1();
        logic [63:0] got, exp;
        logic [7:0]  echo;
        run_frame(2, 8, 32'h01, 16, got);
        exp = exp_echo(8, 32'h01, 16);
        for (int k = 0; k < 8; k++) echo[7 - k] = got[8 + k];
        nvec++;
        if (got !== exp || echo !== 8'h80) begin
            nerr++;
            $display("FAIL cpol1_echo: stream=%h echo=%h, need stream=%h echo=80",
                     got[15:0], echo, exp[15:0]);
        end
        nvec++;
        if (rx_c !== 8'h01) begin
            nerr++;
            $display("FAIL cpol1_rx_data: got=%h need=01", rx_c);
        end
    endtask

    task automatic test_abort();
        logic [63:0] got, exp;
        logic        s;
        logic [4:0]  seen;
        int v0;
`ifdef SPI_BITREV_FRAME_ERR_EN
        int f0;
        f0 = fcnt_a;
`endif
        v0 = vcnt_a;
        ss_set(0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            sck_cycle(0, 1'($urandom), s);
            seen[j] = s;
        end
        ss_set(0, 1'b1);
        nvec++;
        if (seen !== 5'b11111 || miso_a !== 1'b1) begin
            nerr++;
            $display("FAIL abort_miso_idle: rx_phase=%b now=%b, need 11111 and 1", seen, miso_a);
        end
        nvec++;
        if (vcnt_a != v0 || rx_a !== last_a[7:0]) begin
            nerr++;
            $display("FAIL abort_no_valid: valids=%0d rx=%h, need 0 and %h", vcnt_a - v0, rx_a, last_a[7:0]);
        end
        run_frame(0, 8, 32'hA5, 16, got);
        exp = exp_echo(8, 32'hA5, 16);
        last_a = 32'hA5;
        nvec++;
        if (got !== exp || rx_a !== 8'hA5 || vcnt_a - v0 != 1) begin
            nerr++;
            $display("FAIL abort_next_frame: stream=%h rx=%h valids=%0d, need %h a5 1",
                     got[15:0], rx_a, vcnt_a - v0, exp[15:0]);
        end
`ifdef SPI_BITREV_FRAME_ERR_EN
        nvec++;
        if (fcnt_a - f0 != 1) begin
            nerr++;
            $display("FAIL abort_frame_err: pulses=%0d need=1", fcnt_a - f0);
        end
`endif
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        logic [31:0] word;
        int i, w, nclk, v0;
        for (int n = 0; n < 9; n++) begin
            i    = n % 3;
            w    = width_of(i);
            word = $urandom & ((32'd1 << w) - 1);
            nclk = 2 * w + int'($urandom_range(0, 3));
            v0   = get_vcnt(i);
            run_frame(i, w, word, nclk, got);
            exp = exp_echo(w, word, nclk);
            if (i == 0) last_a = word;
            nvec++;
            if (got !== exp || get_rx(i) !== word || get_vcnt(i) - v0 != 1) begin
                nerr++;
                $display("FAIL random_frame inst%0d word=%h: stream=%h rx=%h valids=%0d, need stream=%h",
                         i, word, got, get_rx(i), get_vcnt(i) - v0, exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] got, exp;
        logic [31:0] word;
        logic        s;
        logic [4:0]  seen;
        int v0;
        word = $urandom & 32'hFF;
        ss_set(0, 1'b0);
        for (int j = 0; j < 11; j++)
            sck_cycle(0, (j < 8) ? word[7 - j] : 1'b0, s);
        wait_clk(4);
        resetn = 1'b0;
        #1;
        nvec++;
        if (miso_a !== 1'b1 || rx_a !== 8'd0) begin
            nerr++;
            $display("FAIL midframe_reset: miso=%b rx=%h, need 1 and 00", miso_a, rx_a);
        end
        wait_clk(2);
        resetn = 1'b1;
        v0 = vcnt_a;
        for (int j = 0; j < 5; j++) begin
            sck_cycle(0, 1'($urandom), s);
            seen[j] = s;
        end
        nvec++;
        if (seen !== 5'b11111 || vcnt_a != v0 || rx_a !== 8'd0) begin
            nerr++;
            $display("FAIL midframe_no_restart: miso=%b valids=%0d rx=%h, need 11111 0 00",
                     seen, vcnt_a - v0, rx_a);
        end
        ss_set(0, 1'b1);
        run_frame(0, 8, 32'h3C, 16, got);
        exp = exp_echo(8, 32'h3C, 16);
        nvec++;
        if (got !== exp || rx_a !== 8'h3C || vcnt_a - v0 != 1) begin
            nerr++;
            $display("FAIL midframe_recover: stream=%h rx=%h valids=%0d, need %h 3c 1",
                     got[15:0], rx_a, vcnt_a - v0, exp[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_b4();
        test_wide_8001();
        test_cpol1();
        test_abort();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
